// File: rtl/fetch_queue_ctrl_if.sv
// Fetch queue controller handshake bundle: memory return, decode stall/flush,
// and the queue/memory mux controls back toward decode and fetch.
interface fetch_queue_ctrl_if #(
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [IWIDTH-1:0] iq_i_mem_instr;
  logic              iq_i_mem_valid;
  logic              iq_i_stall;
  logic              iq_i_flush;
  logic [IWIDTH-1:0] iq_o_queue_instr;
  logic              iq_o_check_queue;
  logic              iq_o_valid;
  logic              iq_o_fetch_stall;
  logic [CW-1:0]     iq_o_count;

  modport master (
    output iq_i_mem_instr, iq_i_mem_valid, iq_i_stall, iq_i_flush,
    input  iq_o_queue_instr, iq_o_check_queue, iq_o_valid,
           iq_o_fetch_stall, iq_o_count
  );

  modport slave (
    input  iq_i_mem_instr, iq_i_mem_valid, iq_i_stall, iq_i_flush,
    output iq_o_queue_instr, iq_o_check_queue, iq_o_valid,
           iq_o_fetch_stall, iq_o_count
  );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// Instruction queue between imem and decode: bypasses when empty, buffers
// returns while decode stalls, and drops in-flight returns after a flush.
module fetch_queue_ctrl #(
  parameter int unsigned IWIDTH     = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned FLUSH_DROP = 1
) (
  input  logic iq_clk,
  input  logic iq_rst,
  fetch_queue_ctrl_if.slave iq
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = $clog2(FLUSH_DROP + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [DW-1:0] DROP_CNT = DW'(FLUSH_DROP);

  localparam logic [1:0] BYPASS = 2'd0;
  localparam logic [1:0] QUEUE  = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  logic [1:0]        state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [PW-1:0]     wp, wp_n, rp, rp_n;
  logic [DW-1:0]     drop, drop_n;
  logic              wr_en, enq, deq;
  logic              full, empty;
  logic [IWIDTH-1:0] storage [DEPTH];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_comb begin
    state_n = state;
    count_n = count;
    wp_n    = wp;
    rp_n    = rp;
    drop_n  = drop;
    wr_en   = 1'b0;
    enq     = 1'b0;
    deq     = 1'b0;
    if (iq.iq_i_flush) begin
      state_n = FLUSH;
      count_n = '0;
      wp_n    = '0;
      rp_n    = '0;
      drop_n  = DROP_CNT;
    end else begin
      case (state)
        BYPASS: begin
          if (iq.iq_i_mem_valid && iq.iq_i_stall) begin
            wr_en   = 1'b1;
            wp_n    = wp + PW'(1);
            count_n = CW'(1);
            state_n = QUEUE;
          end
        end
        QUEUE: begin
          deq = !iq.iq_i_stall;
          enq = iq.iq_i_mem_valid && !full;
          if (enq) begin
            wr_en = 1'b1;
            wp_n  = wp + PW'(1);
          end
          if (deq) rp_n = rp + PW'(1);
          count_n = count + CW'(enq) - CW'(deq);
          if (count_n == '0) state_n = BYPASS;
        end
        FLUSH: begin
          if (drop <= DW'(1)) begin
            drop_n  = '0;
            state_n = BYPASS;
          end else begin
            drop_n = drop - DW'(1);
          end
        end
        default: state_n = BYPASS;
      endcase
    end
  end

  always_ff @(posedge iq_clk or negedge iq_rst) begin
    if (!iq_rst) begin
      state <= BYPASS;
      count <= '0;
      wp    <= '0;
      rp    <= '0;
      drop  <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      wp    <= wp_n;
      rp    <= rp_n;
      drop  <= drop_n;
    end
  end

  always_ff @(posedge iq_clk or negedge iq_rst) begin
    if (!iq_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else if (wr_en) begin
      storage[wp] <= iq.iq_i_mem_instr;
    end
  end

  assign iq.iq_o_check_queue = (state == QUEUE);
  assign iq.iq_o_queue_instr = empty ? '0 : storage[rp];
  // Only BYPASS forwards the live memory response; FLUSH always reports invalid.
  assign iq.iq_o_valid       = (state == QUEUE) ||
                               ((state == BYPASS) && iq.iq_i_mem_valid && !iq.iq_i_flush);
  assign iq.iq_o_fetch_stall = full;
  assign iq.iq_o_count       = count;
endmodule

// File: doc/fetch_queue_ctrl.md
# fetch_queue_ctrl

Fetch-side instruction queue controller for the superscalar front end. It buffers instructions returned by instruction memory while decode is stalled, and drives the select of the queue/memory instruction mux (`check_queue`). It also drives the head-of-queue instruction into that mux and back-pressures the PC/fetch stage when the buffer is full. It sits between instruction memory and the queue/memory mux feeding decode, and owns the queue storage, pointers, occupancy and flush recovery.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `FLUSH_DROP`, 1: memory responses discarded after a flush; imem read latency; ≥1.
- `iq_clk` input 1: clock, rising edge.
- `iq_rst` input 1: asynchronous, active-low reset.
- `iq_i_mem_instr` input `IWIDTH`: instruction returned by instruction memory.
- `iq_i_mem_valid` input 1: `iq_i_mem_instr` valid this cycle.
- `iq_i_stall` input 1: decode cannot accept an instruction this cycle.
- `iq_i_flush` input 1: redirect (branch/jump); discard all buffered and in-flight instructions.
- `iq_o_queue_instr` output `IWIDTH`: head entry, to mux queue input.
- `iq_o_check_queue` output 1: mux select; 1 = queue head, 0 = memory.
- `iq_o_valid` output 1: mux output is a valid instruction this cycle.
- `iq_o_fetch_stall` output 1: queue full; fetch holds PC and re-presents the same instruction.
- `iq_o_count` output $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage: DEPTH × `IWIDTH` registers, write pointer `wp`, read pointer `rp`, both $clog2(DEPTH) bits, wrap modulo DEPTH; `count` 0..DEPTH.
- `full` = (count == DEPTH); `empty` = (count == 0).
- FSM states: BYPASS, QUEUE, FLUSH.
- BYPASS (empty, check_queue = 0):
  - mem_valid & !stall: instruction passes straight through the mux; no enqueue.
  - mem_valid & stall: enqueue at `wp`; next state QUEUE.
  - !mem_valid: nothing.
- QUEUE (count ≥ 1, check_queue = 1):
  - deq = !stall: head consumed, `rp` advances.
  - enq = mem_valid & !full: written at `wp`, `wp` advances. mem_valid while full is ignored; fetch_stall guarantees re-presentation.
  - Simultaneous enq and deq: count unchanged; a write and a read at the same index are never both live, since count ≥ 1.
  - Next state is BYPASS when the next count = 0, i.e. count = 1, deq, no enq.
- FLUSH: entered from any state on `iq_i_flush`.
  - In the flush cycle: count, wp and rp are cleared to 0. The mem_valid response of that cycle is dropped and nothing is dequeued.
  - Remains in FLUSH for FLUSH_DROP cycles, counted by an internal down-counter. Each mem_valid during this window is dropped, and iq_o_valid = 0.
  - Then moves to BYPASS.
  - A flush asserted while already in FLUSH reloads the counter to FLUSH_DROP.
- Flush has priority over enqueue, dequeue and all state transitions.
- Outputs:
  - `iq_o_check_queue` = (state == QUEUE).
  - `iq_o_queue_instr` = storage[rp] when !empty, else 0.
  - `iq_o_valid` = QUEUE ? 1 : (BYPASS & mem_valid & !flush); 0 in FLUSH.
  - `iq_o_fetch_stall` = full.
  - `iq_o_count` = count.
- Instruction order out of the mux always equals memory return order.

## Timing
- Reset (iq_rst low, asynchronous): state BYPASS, count/wp/rp/flush counter = 0, storage cleared. `iq_o_check_queue`=0, `iq_o_queue_instr`=0, `iq_o_valid`=0, `iq_o_fetch_stall`=0, `iq_o_count`=0. Reset mid-operation discards all entries immediately. Release is synchronous to the next rising edge.
- `iq_o_check_queue`, `iq_o_fetch_stall`, `iq_o_count`, `iq_o_queue_instr` depend only on registered state; there is no combinational path from inputs.
- `iq_o_valid` is combinational from `iq_i_mem_valid`/`iq_i_flush` in BYPASS only.
- Bypass latency 0 cycles. An instruction enqueued in cycle N is at the head in cycle N+1 if the queue was empty.
- Full asserted the cycle after the DEPTH-th entry is written. It deasserts the cycle after the first dequeue from full.

## Test plan
- Bypass: stall=0, mem_valid=1 with instrs A,B,C on consecutive cycles -> check_queue=0 throughout; mux output A,B,C with valid=1; count stays 0.
- Stall capture/drain: stall=1 for 3 cycles while A,B,C return, then stall=0 -> count 1,2,3. Then check_queue=1 and head A,B,C on successive cycles; count 2,1,0; back to BYPASS with check_queue=0.
- Full: DEPTH=4, stall=1, 6 instrs presented -> count=4, fetch_stall=1 after 4th. The 5th/6th are ignored until stall drops; after one deq, fetch_stall=0 the next cycle.
- Simultaneous enq/deq at count=2, stall=0, mem_valid=1 -> count stays 2; output order preserved across pointer wrap (run ≥ 2×DEPTH instrs).
- Flush: count=3, flush=1 with mem_valid=1 -> next cycle count=0 and valid=0. The instruction arriving in the following FLUSH_DROP=1 cycle is dropped; the next instruction bypasses with valid=1.
- Async reset mid-QUEUE (count=2) -> all outputs 0 immediately without a clock edge; normal bypass resumes after release.
